// File: rtl/direction_light_fsm_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | direction_light_fsm_if : scheduler <-> per-direction light sequencer |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
interface direction_light_fsm_if #(
  parameter int CNT_W = 6
);
  logic             enable;
  logic             clear;
  logic             service;
  logic             light_red;
  logic             light_yellow;
  logic             light_green;
  logic             done;
  logic             busy;
  logic [CNT_W-1:0] remaining;

  modport master (
    output enable, clear, service,
    input  light_red, light_yellow, light_green, done, busy, remaining
  );

  modport slave (
    input  enable, clear, service,
    output light_red, light_yellow, light_green, done, busy, remaining
  );
endinterface
`default_nettype wire

// File: rtl/direction_light_fsm.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | direction_light_fsm : timed green/yellow/all-red sequencer with      |
// | service (blinking yellow) mode and safe abort. Revision 1.0          |
// +----------------------------------------------------------------------+
module direction_light_fsm #(
  parameter int TICK_DIV    = 50_000_000,
  parameter int GREEN_S     = 20,
  parameter int YELLOW_S    = 3,
  parameter int RED_CLEAR_S = 2,
  parameter int CNT_W       = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  direction_light_fsm_if.slave bus
);

  localparam int               c_PW        = $clog2(TICK_DIV);
  localparam logic [c_PW-1:0]  c_TICK_LAST = c_PW'(TICK_DIV - 1);
  localparam logic [c_PW-1:0]  c_PONE      = c_PW'(1);
  localparam logic [CNT_W-1:0] c_ONE       = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_ZERO      = '0;
  localparam logic [CNT_W-1:0] c_GREEN     = CNT_W'(GREEN_S);
  localparam logic [CNT_W-1:0] c_YELLOW    = CNT_W'(YELLOW_S);
  localparam logic [CNT_W-1:0] c_RED_CLR   = CNT_W'(RED_CLEAR_S);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_GREEN    = 3'd1,
    S_YELLOW   = 3'd2,
    S_ALL_RED  = 3'd3,
    S_DONE     = 3'd4,
    S_WAIT_REL = 3'd5,
    S_SERVICE  = 3'd6
  } state_t;

  state_t           r_state;
  state_t           w_nxt;
  logic [c_PW-1:0]  r_presc;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt;
  logic             r_abort;
  logic             w_abort;
  logic             r_svc_yel;
  logic             w_svc_yel;
  logic             w_tick;
  logic             w_chg;
  logic             r_red;
  logic             r_yellow;
  logic             r_green;
  logic             r_done;
  logic             r_busy;

  assign w_tick = (r_presc == c_TICK_LAST);
  assign w_chg  = (w_nxt != r_state);

  always_comb begin
    w_nxt     = r_state;
    w_cnt     = r_cnt;
    w_abort   = r_abort;
    w_svc_yel = r_svc_yel;
    case (r_state)
      S_IDLE: begin
        if (!bus.clear) begin
          if (bus.service) begin
            w_nxt     = S_SERVICE;
            w_svc_yel = 1'b1;
            w_cnt     = c_ZERO;
          end else if (bus.enable) begin
            w_nxt   = S_GREEN;
            w_cnt   = c_GREEN;
            w_abort = 1'b0;
          end
        end
      end
      S_GREEN: begin
        // An abort still serves yellow and clearance; green never drops to red.
        if (bus.clear) begin
          w_nxt   = S_YELLOW;
          w_cnt   = c_YELLOW;
          w_abort = 1'b1;
        end else if (w_tick) begin
          if (r_cnt == c_ONE) begin
            w_nxt = S_YELLOW;
            w_cnt = c_YELLOW;
          end else begin
            w_cnt = r_cnt - c_ONE;
          end
        end
      end
      S_YELLOW: begin
        if (bus.clear)
          w_abort = 1'b1;
        if (w_tick) begin
          if (r_cnt == c_ONE) begin
            w_nxt = S_ALL_RED;
            w_cnt = c_RED_CLR;
          end else begin
            w_cnt = r_cnt - c_ONE;
          end
        end
      end
      S_ALL_RED: begin
        if (bus.clear) begin
          w_nxt = S_IDLE;
          w_cnt = c_ZERO;
        end else if (w_tick) begin
          if (r_cnt == c_ONE) begin
            w_nxt = r_abort ? S_IDLE : S_DONE;
            w_cnt = c_ZERO;
          end else begin
            w_cnt = r_cnt - c_ONE;
          end
        end
      end
      S_DONE: begin
        w_nxt = bus.enable ? S_WAIT_REL : S_IDLE;
      end
      S_WAIT_REL: begin
        if (bus.clear) begin
          w_nxt = S_IDLE;
        end else if (bus.service) begin
          w_nxt     = S_SERVICE;
          w_svc_yel = 1'b1;
        end else if (!bus.enable) begin
          w_nxt = S_IDLE;
        end
      end
      S_SERVICE: begin
        if (bus.clear || !bus.service) begin
          w_nxt   = S_ALL_RED;
          w_cnt   = c_RED_CLR;
          w_abort = 1'b1;
        end else if (w_tick) begin
          w_svc_yel = ~r_svc_yel;
        end
      end
      default: begin
        w_nxt = S_IDLE;
        w_cnt = c_ZERO;
      end
    endcase
  end

  // Lamps and status are decoded from the next state so they switch with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_presc   <= '0;
      r_cnt     <= '0;
      r_abort   <= 1'b0;
      r_svc_yel <= 1'b0;
      r_red     <= 1'b1;
      r_yellow  <= 1'b0;
      r_green   <= 1'b0;
      r_done    <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_nxt;
      r_presc   <= (w_chg || w_tick) ? '0 : r_presc + c_PONE;
      r_cnt     <= w_cnt;
      r_abort   <= w_abort;
      r_svc_yel <= w_svc_yel;
      r_red     <= (w_nxt == S_IDLE) || (w_nxt == S_ALL_RED) ||
                   (w_nxt == S_DONE) || (w_nxt == S_WAIT_REL);
      r_yellow  <= (w_nxt == S_YELLOW) || ((w_nxt == S_SERVICE) && w_svc_yel);
      r_green   <= (w_nxt == S_GREEN);
      r_done    <= (w_nxt == S_DONE);
      r_busy    <= (w_nxt == S_GREEN) || (w_nxt == S_YELLOW) ||
                   (w_nxt == S_ALL_RED) || (w_nxt == S_DONE);
    end
  end

  assign bus.light_red    = r_red;
  assign bus.light_yellow = r_yellow;
  assign bus.light_green  = r_green;
  assign bus.done         = r_done;
  assign bus.busy         = r_busy;
  assign bus.remaining    = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_direction_light_fsm.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_direction_light_fsm : scoreboard bench for direction_light_fsm    |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_direction_light_fsm;

  typedef struct {
    string      tag;
    logic [10:0] v;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb_q[$];
  exp_t mon_x;

  direction_light_fsm_if #(.CNT_W(6)) bus();

  direction_light_fsm #(
    .TICK_DIV(4), .GREEN_S(3), .YELLOW_S(2), .RED_CLEAR_S(1), .CNT_W(6)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  wire [10:0] dut_vec = {bus.light_red, bus.light_yellow, bus.light_green,
                         bus.done, bus.busy, bus.remaining};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Vector layout: {red, yellow, green, done, busy, remaining[5:0]}
  function automatic logic [10:0] v(bit r, bit y, bit g, bit d, bit b, int rem);
    return {r, y, g, d, b, 6'(rem)};
  endfunction

  function automatic logic [10:0] e_idle();      return v(1,0,0,0,0,0); endfunction
  function automatic logic [10:0] e_g(int n);    return v(0,0,1,0,1,n); endfunction
  function automatic logic [10:0] e_y(int n);    return v(0,1,0,0,1,n); endfunction
  function automatic logic [10:0] e_ar();        return v(1,0,0,0,1,1); endfunction
  function automatic logic [10:0] e_done();      return v(1,0,0,1,1,0); endfunction
  function automatic logic [10:0] e_son();       return v(0,1,0,0,0,0); endfunction
  function automatic logic [10:0] e_soff();      return v(0,0,0,0,0,0); endfunction

  always @(posedge clk) begin
    #1;
    if (sb_q.size() != 0) begin
      mon_x = sb_q.pop_front();
      check(mon_x.tag, {21'b0, dut_vec}, {21'b0, mon_x.v});
      check("one_lamp", {31'b0, ($countones({bus.light_red, bus.light_yellow,
                                             bus.light_green}) <= 1)}, 32'd1);
    end
  end

  // Inputs are sampled at the next edge; e is the output expected after it.
  task automatic step(bit en, bit clr, bit svc, string tag, logic [10:0] e);
    bus.enable  = en;
    bus.clear   = clr;
    bus.service = svc;
    sb_q.push_back('{tag, e});
    @(posedge clk);
    #2;
  endtask

  task automatic run(bit en, bit clr, bit svc, string tag, logic [10:0] e, int n);
    repeat (n) step(en, clr, svc, tag, e);
  endtask

  // Enable sampled at E0, then a full green/yellow/clearance/done sequence.
  task automatic full_cycle(string tag, bit en_hold, bit svc_hold);
    step(1, 0, 0, tag, e_g(3));
    run(en_hold, 0, svc_hold, tag, e_g(3), 3);
    run(en_hold, 0, svc_hold, tag, e_g(2), 4);
    run(en_hold, 0, svc_hold, tag, e_g(1), 4);
    run(en_hold, 0, svc_hold, tag, e_y(2), 4);
    run(en_hold, 0, svc_hold, tag, e_y(1), 4);
    run(en_hold, 0, svc_hold, tag, e_ar(), 4);
    step(en_hold, 0, svc_hold, tag, e_done());
  endtask

  initial begin
    bus.enable  = 1'b0;
    bus.clear   = 1'b0;
    bus.service = 1'b0;
    #12;
    check("reset_vals", {21'b0, dut_vec}, {21'b0, e_idle()});
    rst_n = 1'b1;
    @(posedge clk);
    #2;
    run(0, 0, 0, "idle", e_idle(), 3);

    // Normal cycle with held enable, no re-service until released
    full_cycle("normal", 1, 0);
    run(1, 0, 0, "wait_rel_hold", e_idle(), 6);
    step(0, 0, 0, "release", e_idle());
    step(1, 0, 0, "restart", e_g(3));
    run(0, 0, 0, "restart", e_g(3), 3);
    run(0, 0, 0, "restart", e_g(2), 4);
    run(0, 0, 0, "restart", e_g(1), 4);
    run(0, 0, 0, "restart", e_y(2), 2);

    // Asynchronous reset mid-yellow
    rst_n = 1'b0;
    #1;
    check("async_reset", {21'b0, dut_vec}, {21'b0, e_idle()});
    #1;
    rst_n = 1'b1;
    step(0, 0, 0, "post_rst_idle", e_idle());
    full_cycle("post_rst", 0, 0);
    run(0, 0, 0, "post_rst_idle", e_idle(), 2);

    // Clear during green
    step(1, 0, 0, "clr_green", e_g(3));
    run(0, 0, 0, "clr_green", e_g(3), 3);
    run(0, 0, 0, "clr_green", e_g(2), 2);
    step(0, 1, 0, "clr_green", e_y(2));
    run(0, 0, 0, "clr_green", e_y(2), 3);
    run(0, 0, 0, "clr_green", e_y(1), 4);
    run(0, 0, 0, "clr_green", e_ar(), 4);
    run(0, 0, 0, "clr_green_idle", e_idle(), 3);

    // Clear during all-red
    step(1, 0, 0, "clr_red", e_g(3));
    run(0, 0, 0, "clr_red", e_g(3), 3);
    run(0, 0, 0, "clr_red", e_g(2), 4);
    run(0, 0, 0, "clr_red", e_g(1), 4);
    run(0, 0, 0, "clr_red", e_y(2), 4);
    run(0, 0, 0, "clr_red", e_y(1), 4);
    run(0, 0, 0, "clr_red", e_ar(), 2);
    step(0, 1, 0, "clr_red_idle", e_idle());
    run(0, 0, 0, "clr_red_idle", e_idle(), 2);

    // Service mode blink and exit clearance
    step(0, 0, 1, "svc", e_son());
    run(0, 0, 1, "svc", e_son(), 3);
    run(0, 0, 1, "svc", e_soff(), 4);
    run(0, 0, 1, "svc", e_son(), 4);
    run(0, 0, 0, "svc_clear", e_ar(), 4);
    run(0, 0, 0, "svc_idle", e_idle(), 2);

    // Service during green is ignored
    full_cycle("svc_in_green", 0, 1);
    run(0, 0, 0, "svc_in_green_idle", e_idle(), 2);

    // Enable and service together: service wins
    step(1, 0, 1, "both", e_son());
    run(1, 0, 1, "both", e_son(), 3);
    run(1, 0, 1, "both", e_soff(), 2);
    run(0, 0, 0, "both_clear", e_ar(), 4);
    run(0, 0, 0, "both_idle", e_idle(), 2);

    @(posedge clk);
    #2;
    check("sb_empty", sb_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
